// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - RV32I decode stage: regfile read, forwarding, load-use stall, branch resolve.
// Optional ID_STALL_CNT_EN adds stall_cnt_o, a saturating count of load-use stall cycles.
module id_pipe #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int FWD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  output logic [4:0]                rs1_addr_o,
  output logic [4:0]                rs2_addr_o,
  input  logic [XLEN-1:0]           rs1_data_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic [FWD_PORTS-1:0]      fwd_en_i,
  input  logic [5*FWD_PORTS-1:0]    fwd_addr_i,
  input  logic [XLEN*FWD_PORTS-1:0] fwd_data_i,
  input  logic                      ex_load_i,
  input  logic [4:0]                ex_rd_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         pc_o,
  output logic [6:0]                opcode_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o,
  output logic [XLEN-1:0]           imm_o,
  output logic                      wreg_en_o,
  output logic [4:0]                wreg_addr_o,
  output logic [XLEN-1:0]           rs1_data_o,
  output logic [XLEN-1:0]           rs2_data_o,
  output logic                      wmem_en_o,
  output logic                      rmem_en_o,
  output logic                      branch_taken_o,
  output logic [ADDR_W-1:0]         branch_target_o,
  output logic                      illegal_o
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam logic [4:0] C_LOAD   = 5'b00000;
  localparam logic [4:0] C_STORE  = 5'b01000;
  localparam logic [4:0] C_OPIMM  = 5'b00100;
  localparam logic [4:0] C_OP     = 5'b01100;
  localparam logic [4:0] C_LUI    = 5'b01101;
  localparam logic [4:0] C_AUIPC  = 5'b00101;
  localparam logic [4:0] C_JAL    = 5'b11011;
  localparam logic [4:0] C_JALR   = 5'b11001;
  localparam logic [4:0] C_BRANCH = 5'b11000;

  logic [6:0] opcode;
  logic [4:0] cls, rd, rs1, rs2;
  logic [2:0] funct3;
  logic       std_op;

  assign opcode = inst_i[6:0];
  assign cls    = inst_i[6:2];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign std_op = (opcode[1:0] == 2'b11);

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  logic is_load, is_store, is_opimm, is_op, is_lui, is_auipc, is_jal, is_jalr, is_branch;
  assign is_load   = std_op & (cls == C_LOAD);
  assign is_store  = std_op & (cls == C_STORE);
  assign is_opimm  = std_op & (cls == C_OPIMM);
  assign is_op     = std_op & (cls == C_OP);
  assign is_lui    = std_op & (cls == C_LUI);
  assign is_auipc  = std_op & (cls == C_AUIPC);
  assign is_jal    = std_op & (cls == C_JAL);
  assign is_jalr   = std_op & (cls == C_JALR);
  assign is_branch = std_op & (cls == C_BRANCH);

  logic legal_cls, bad_branch, illegal;
  assign legal_cls  = is_load | is_store | is_opimm | is_op | is_lui | is_auipc |
                      is_jal | is_jalr | is_branch;
  // funct3 010/011 have no branch meaning; flagged and never taken
  assign bad_branch = is_branch & (funct3[2:1] == 2'b01);
  assign illegal    = ~legal_cls | bad_branch;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;

  always_comb begin
    imm32 = '0;
    if (is_load | is_opimm | is_jalr)
      imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
    else if (is_store)
      imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    else if (is_branch)
      imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    else if (is_lui | is_auipc)
      imm32 = {inst_i[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  end

  assign imm = XLEN'(signed'(imm32));

  // Lowest-index enabled source wins, so scan from the highest index down
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] v;
    v = rf;
    for (int i = FWD_PORTS - 1; i >= 0; i--)
      if (fwd_en_i[i] && (fwd_addr_i[5*i +: 5] == a))
        v = fwd_data_i[XLEN*i +: XLEN];
    if (a == 5'd0)
      v = '0;
    return v;
  endfunction

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = resolve(rs1, rs1_data_i);
  assign rs2_val = resolve(rs2, rs2_data_i);

  logic cond;
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  cond = (rs1_val <  rs2_val);
      3'b111:  cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  logic              taken;
  logic [ADDR_W-1:0] imm_a, jalr_sum, target;

  assign taken    = (is_branch & cond) | is_jal | is_jalr;
  assign imm_a    = ADDR_W'(imm);
  assign jalr_sum = ADDR_W'(rs1_val) + imm_a;

  always_comb begin
    target = pc_i + ADDR_W'(4);
    if (is_branch | is_jal)
      target = pc_i + imm_a;
    else if (is_jalr)
      target = {jalr_sum[ADDR_W-1:1], 1'b0};
  end

  logic rs1_used, rs2_used, hazard, accept, wreg_en;
  assign rs1_used = is_load | is_store | is_opimm | is_op | is_jalr | is_branch;
  assign rs2_used = is_op | is_store | is_branch;
  assign hazard   = in_valid & ex_load_i & (ex_rd_i != 5'd0) &
                    ((rs1_used & (rs1 == ex_rd_i)) | (rs2_used & (rs2 == ex_rd_i)));
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;
  assign wreg_en  = (is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr) &
                    (rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      pc_o            <= '0;
      opcode_o        <= '0;
      funct3_o        <= '0;
      funct7_o        <= '0;
      imm_o           <= '0;
      wreg_en_o       <= 1'b0;
      wreg_addr_o     <= '0;
      rs1_data_o      <= '0;
      rs2_data_o      <= '0;
      wmem_en_o       <= 1'b0;
      rmem_en_o       <= 1'b0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
      illegal_o       <= 1'b0;
    end else begin
      if (flush_i)
        out_valid <= 1'b0;
      else if (accept)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        pc_o            <= pc_i;
        opcode_o        <= opcode;
        funct3_o        <= funct3;
        funct7_o        <= inst_i[31:25];
        imm_o           <= imm;
        wreg_en_o       <= wreg_en;
        wreg_addr_o     <= rd;
        rs1_data_o      <= rs1_val;
        rs2_data_o      <= rs2_val;
        wmem_en_o       <= is_store;
        rmem_en_o       <= is_load;
        branch_taken_o  <= taken;
        branch_target_o <= target;
        illegal_o       <= illegal;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (hazard && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - vector table plus hand sequences for id_pipe, scoreboard on the output handshake.
module tb_id_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [1:0]  fwd_en_i = '0;
  logic [9:0]  fwd_addr_i = '0;
  logic [63:0] fwd_data_i = '0;
  logic        ex_load_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        wreg_en_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        wmem_en_o, rmem_en_o, branch_taken_o, illegal_o;
  logic [31:0] branch_target_o;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_en_i(fwd_en_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .imm_o(imm_o),
    .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wmem_en_o(wmem_en_o), .rmem_en_o(rmem_en_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
    .illegal_o(illegal_o)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, rs1d, rs2d;
    logic [1:0]  fen;
    logic [9:0]  faddr;
    logic [63:0] fdata;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [31:0] e_imm;
    logic        imm_chk;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_r1, e_r2;
    logic        e_wmem, e_rmem, e_taken;
    logic [31:0] e_tgt;
    logic        e_ill;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] pc, inst, rs1d, rs2d, input logic [1:0] fen, input logic [9:0] faddr,
    input logic [63:0] fdata, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [31:0] imm, input logic ichk, input logic wen, input logic [4:0] wa,
    input logic [31:0] r1, r2, input logic wm, rm, tk, input logic [31:0] tgt, input logic ill);
    vec_t v;
    v.pc = pc; v.inst = inst; v.rs1d = rs1d; v.rs2d = rs2d;
    v.fen = fen; v.faddr = faddr; v.fdata = fdata;
    v.e_op = op; v.e_f3 = f3; v.e_f7 = f7; v.e_imm = imm; v.imm_chk = ichk;
    v.e_wen = wen; v.e_wa = wa; v.e_r1 = r1; v.e_r2 = r2;
    v.e_wmem = wm; v.e_rmem = rm; v.e_taken = tk; v.e_tgt = tgt; v.e_ill = ill;
    return v;
  endfunction

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t q[$];
  vec_t tbl[16];
  vec_t hz, mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    pc_i = v.pc; inst_i = v.inst; rs1_data_i = v.rs1d; rs2_data_i = v.rs2d;
    fwd_en_i = v.fen; fwd_addr_i = v.faddr; fwd_data_i = v.fdata;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input vec_t v, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush_i) q.push_back(v);
        break;
      end
      n++;
      if (n > 20) begin
        check($sformatf("accept_timeout@%h", v.pc), 32'(n), 32'd0);
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check($sformatf("pc_o@%h", mon_e.pc), pc_o, mon_e.pc);
        check($sformatf("opcode_o@%h", mon_e.pc), 32'(opcode_o), 32'(mon_e.e_op));
        check($sformatf("funct3_o@%h", mon_e.pc), 32'(funct3_o), 32'(mon_e.e_f3));
        check($sformatf("funct7_o@%h", mon_e.pc), 32'(funct7_o), 32'(mon_e.e_f7));
        if (mon_e.imm_chk) check($sformatf("imm_o@%h", mon_e.pc), imm_o, mon_e.e_imm);
        check($sformatf("wreg_en_o@%h", mon_e.pc), 32'(wreg_en_o), 32'(mon_e.e_wen));
        check($sformatf("wreg_addr_o@%h", mon_e.pc), 32'(wreg_addr_o), 32'(mon_e.e_wa));
        check($sformatf("rs1_data_o@%h", mon_e.pc), rs1_data_o, mon_e.e_r1);
        check($sformatf("rs2_data_o@%h", mon_e.pc), rs2_data_o, mon_e.e_r2);
        check($sformatf("wmem_en_o@%h", mon_e.pc), 32'(wmem_en_o), 32'(mon_e.e_wmem));
        check($sformatf("rmem_en_o@%h", mon_e.pc), 32'(rmem_en_o), 32'(mon_e.e_rmem));
        check($sformatf("branch_taken_o@%h", mon_e.pc), 32'(branch_taken_o), 32'(mon_e.e_taken));
        check($sformatf("branch_target_o@%h", mon_e.pc), branch_target_o, mon_e.e_tgt);
        check($sformatf("illegal_o@%h", mon_e.pc), 32'(illegal_o), 32'(mon_e.e_ill));
      end
    end
  end

  initial begin
    int n;
    //                pc        inst          rs1d          rs2d     fen    faddr          fdata                 op     f3 f7     imm           ichk wen wa     r1            r2        wm rm tk tgt           ill
    tbl[0]  = mk(32'h100, 32'h00500093, 32'hDEAD,     32'h55,  2'b01, {5'd0,5'd0}, {32'h0,32'h99},     7'h13, 0, 7'h00, 32'd5,        1, 1, 5'd1,  32'h0,        32'h55,   0, 0, 0, 32'h104,     0);
    tbl[1]  = mk(32'h200, 32'h00208463, 32'h33,       32'd7,   2'b11, {5'd1,5'd1}, {32'd9,32'd7},      7'h63, 0, 7'h00, 32'd8,        1, 0, 5'd8,  32'd7,        32'd7,    0, 0, 1, 32'h208,     0);
    tbl[2]  = mk(32'h200, 32'h00208463, 32'h33,       32'd8,   2'b11, {5'd1,5'd1}, {32'd9,32'd7},      7'h63, 0, 7'h00, 32'd8,        1, 0, 5'd8,  32'd7,        32'd8,    0, 0, 0, 32'h208,     0);
    tbl[3]  = mk(32'h300, 32'h004100e7, 32'h1001,     32'h44,  2'b00, 10'd0,       64'd0,              7'h67, 0, 7'h00, 32'd4,        1, 1, 5'd1,  32'h1001,     32'h44,   0, 0, 1, 32'h1004,    0);
    tbl[4]  = mk(32'h340, 32'h00000000, 32'h5,        32'h6,   2'b00, 10'd0,       64'd0,              7'h00, 0, 7'h00, 32'd0,        0, 0, 5'd0,  32'h0,        32'h0,    0, 0, 0, 32'h344,     1);
    tbl[5]  = mk(32'h400, 32'h123452B7, 32'h11,       32'h22,  2'b00, 10'd0,       64'd0,              7'h37, 5, 7'h09, 32'h12345000, 1, 1, 5'd5,  32'h11,       32'h22,   0, 0, 0, 32'h404,     0);
    tbl[6]  = mk(32'h500, 32'h00001017, 32'h77,       32'h88,  2'b00, 10'd0,       64'd0,              7'h17, 1, 7'h00, 32'h1000,     1, 0, 5'd0,  32'h0,        32'h0,    0, 0, 0, 32'h504,     0);
    tbl[7]  = mk(32'h600, 32'hFE20AE23, 32'h11,       32'h22,  2'b10, {5'd2,5'd1}, {32'hBBBB,32'hAAAA}, 7'h23, 2, 7'h7F, 32'hFFFFFFFC, 1, 0, 5'h1C, 32'h11,       32'hBBBB, 1, 0, 0, 32'h604,     0);
    tbl[8]  = mk(32'h640, 32'h00802183, 32'h10,       32'h20,  2'b00, 10'd0,       64'd0,              7'h03, 2, 7'h00, 32'd8,        1, 1, 5'd3,  32'h0,        32'h20,   0, 1, 0, 32'h644,     0);
    tbl[9]  = mk(32'h4,   32'hFF9FF0EF, 32'h31,       32'h32,  2'b00, 10'd0,       64'd0,              7'h6F, 7, 7'h7F, 32'hFFFFFFF8, 1, 1, 5'd1,  32'h31,       32'h32,   0, 0, 1, 32'hFFFFFFFC, 0);
    tbl[10] = mk(32'h700, 32'h0020C863, 32'hFFFFFFFF, 32'd1,   2'b00, 10'd0,       64'd0,              7'h63, 4, 7'h00, 32'd16,       1, 0, 5'd16, 32'hFFFFFFFF, 32'd1,    0, 0, 1, 32'h710,     0);
    tbl[11] = mk(32'h700, 32'h0020E863, 32'hFFFFFFFF, 32'd1,   2'b00, 10'd0,       64'd0,              7'h63, 6, 7'h00, 32'd16,       1, 0, 5'd16, 32'hFFFFFFFF, 32'd1,    0, 0, 0, 32'h710,     0);
    tbl[12] = mk(32'h700, 32'h0020D863, 32'd5,        32'd5,   2'b00, 10'd0,       64'd0,              7'h63, 5, 7'h00, 32'd16,       1, 0, 5'd16, 32'd5,        32'd5,    0, 0, 1, 32'h710,     0);
    tbl[13] = mk(32'h700, 32'h00209863, 32'd5,        32'd5,   2'b00, 10'd0,       64'd0,              7'h63, 1, 7'h00, 32'd16,       1, 0, 5'd16, 32'd5,        32'd5,    0, 0, 0, 32'h710,     0);
    tbl[14] = mk(32'h700, 32'h0020A863, 32'd1,        32'd2,   2'b00, 10'd0,       64'd0,              7'h63, 2, 7'h00, 32'd16,       1, 0, 5'd16, 32'd1,        32'd2,    0, 0, 0, 32'h710,     1);
    tbl[15] = mk(32'h800, 32'h40208033, 32'd3,        32'd4,   2'b11, {5'd2,5'd2}, {32'hC1,32'hC0},    7'h33, 0, 7'h20, 32'd0,        0, 0, 5'd0,  32'd3,        32'hC0,   0, 0, 0, 32'h804,     0);
    hz      = mk(32'h900, 32'h00118233, 32'h300,      32'h100, 2'b00, 10'd0,       64'd0,              7'h33, 0, 7'h00, 32'd0,        0, 1, 5'd4,  32'h300,      32'h100,  0, 0, 0, 32'h904,     0);

    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_pc_o", pc_o, 32'd0);
    check("reset_imm_o", imm_o, 32'd0);
    check("reset_wreg_en_o", 32'(wreg_en_o), 32'd0);
    check("reset_branch_taken_o", 32'(branch_taken_o), 32'd0);
`ifdef ID_STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      wait_accept(tbl[i], n);
    end

    // load-use: one stall cycle, one bubble, then accept
    drive(hz);
    ex_load_i = 1'b1;
    ex_rd_i   = 5'd3;
    @(negedge clk);
    check("hazard_in_ready", 32'(in_ready), 32'd0);
    check("hazard_rs1_addr", 32'(rs1_addr_o), 32'd3);
    check("hazard_rs2_addr", 32'(rs2_addr_o), 32'd1);
    @(posedge clk);
    #1;
    ex_load_i = 1'b0;
    wait_accept(hz, n);
    check("hazard_bubble_out_valid", 32'(out_valid), 32'd0);
    check("hazard_accept_delay", 32'(n), 32'd0);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt_after_hazard", stall_cnt, 32'd1);
`endif

    // LUI ignores rs1, so a matching EX load must not stall it
    drive(tbl[5]);
    ex_load_i = 1'b1;
    ex_rd_i   = 5'd8;
    wait_accept(tbl[5], n);
    check("lui_no_hazard_delay", 32'(n), 32'd0);

    // backpressure: held outputs, in_ready low
    drive(tbl[3]);
    ex_load_i = 1'b0;
    wait_accept(tbl[3], n);
    drive(tbl[0]);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_pc_o", pc_o, 32'h300);
      check("bp_target", branch_target_o, 32'h1004);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept(tbl[0], n);
    check("bp_release_delay", 32'(n), 32'd0);

    // flush beats a simultaneous accept
    drive(tbl[8]);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    flush_i  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt_hold", stall_cnt, 32'd1);
`endif

    // reset while backpressured
    drive(tbl[1]);
    wait_accept(tbl[1], n);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_pc_o", pc_o, 32'd0);
`ifdef ID_STALL_CNT_EN
    check("async_rst_stall_cnt", stall_cnt, 32'd0);
`endif
    q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

    drive(tbl[10]);
    wait_accept(tbl[10], n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
